mdv_rx_ctrl: RTL and testbench

Microdrive receive controller, directly downstream of the microdrive replay stage. It consumes that stage's `gap`, `rx_ready` and `dout` outputs. It buffers received bytes in a small FIFO, raises a gap interrupt, and drives the one-hot drive-select lines through the serial select shift register. The CPU-facing register decode reads its status and data ports.

---
 rtl/mdv_rx_ctrl.sv | 133 +++++++++++++
 tb/tb_mdv_rx_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/mdv_rx_ctrl.sv
// Microdrive receive controller: samples the replay stage outputs, buffers bytes
// in a small FIFO, raises the gap interrupt and shifts the drive-select register.
module mdv_rx_ctrl #(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       mdv_gap,
    input  logic       mdv_rx_ready,
    input  logic [7:0] mdv_dout,
    input  logic       selck,
    input  logic       seld,
    input  logic       rd_status,
    input  logic       rd_data,
    input  logic       irq_ack,
    output logic [7:0] mdv_sel,
    output logic [7:0] status,
    output logic [7:0] rx_data,
    output logic       gap_irq
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

    logic          r_gap_s, r_gap_d;
    logic          r_rdy_s, r_rdy_d;
    logic [7:0]    r_dout_s;
    logic [7:0]    r_sel;
    logic          r_gap_irq;
    logic          r_overrun;
    logic [AW-1:0] r_wptr, r_rptr;
    logic [AW:0]   r_count;
    logic [7:0]    r_mem [FIFO_DEPTH];

    logic          w_gap_rise, w_rx_rise;
    logic          w_empty, w_full;
    logic          w_push, w_pop, w_ovr_evt;
    logic [2:0]    w_cnt_sat;

    assign w_gap_rise = r_gap_s & ~r_gap_d;
    assign w_rx_rise  = r_rdy_s & ~r_rdy_d;
    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == FULL_CNT);
    assign w_pop      = rd_data & ~w_empty;
    // A flush swallows a coincident byte; a full FIFO still accepts it when a pop frees a slot.
    assign w_push     = w_rx_rise & ~w_gap_rise & (~w_full | w_pop);
    assign w_ovr_evt  = w_rx_rise & ~w_gap_rise & w_full & ~w_pop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_gap_s  <= 1'b0;
            r_gap_d  <= 1'b0;
            r_rdy_s  <= 1'b0;
            r_rdy_d  <= 1'b0;
            r_dout_s <= '0;
        end else begin
            r_gap_s  <= mdv_gap;
            r_gap_d  <= r_gap_s;
            r_rdy_s  <= mdv_rx_ready;
            r_rdy_d  <= r_rdy_s;
            r_dout_s <= mdv_dout;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sel <= '0;
        end else if (selck) begin
            r_sel <= {r_sel[6:0], seld};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_gap_irq <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (w_gap_rise) begin
                r_gap_irq <= 1'b1;
            end else if (irq_ack) begin
                r_gap_irq <= 1'b0;
            end
            if (w_ovr_evt) begin
                r_overrun <= 1'b1;
            end else if (rd_status) begin
                r_overrun <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (w_gap_rise) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= r_dout_s;
        end
    end

    always_comb begin
        w_cnt_sat = 3'(r_count);
        if (32'(r_count) > 32'd7) begin
            w_cnt_sat = 3'd7;
        end
    end

    assign mdv_sel = r_sel;
    assign gap_irq = r_gap_irq;
    assign rx_data = w_empty ? 8'h00 : r_mem[r_rptr];
    assign status  = {|r_sel, w_cnt_sat, r_gap_irq, r_overrun, ~w_empty, r_gap_s};

endmodule

// File: tb/tb_mdv_rx_ctrl.sv
// Scoreboard bench for mdv_rx_ctrl: stimulus queues hand-computed expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_mdv_rx_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       mdv_gap, mdv_rx_ready, selck, seld, rd_status, rd_data, irq_ack;
    logic [7:0] mdv_dout;
    logic [7:0] mdv_sel, status, rx_data;
    logic       gap_irq;

    localparam int SIG_SEL = 0, SIG_STAT = 1, SIG_RXD = 2, SIG_IRQ = 3;

    typedef struct {
        string      name;
        int         sig;
        logic [7:0] exp;
    } exp_t;

    exp_t q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    mdv_rx_ctrl #(.FIFO_DEPTH(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .mdv_gap      (mdv_gap),
        .mdv_rx_ready (mdv_rx_ready),
        .mdv_dout     (mdv_dout),
        .selck        (selck),
        .seld         (seld),
        .rd_status    (rd_status),
        .rd_data      (rd_data),
        .irq_ack      (irq_ack),
        .mdv_sel      (mdv_sel),
        .status       (status),
        .rx_data      (rx_data),
        .gap_irq      (gap_irq)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin : monitor
        exp_t       e;
        logic [7:0] act;
        while (q.size() > 0) begin
            e = q.pop_front();
            case (e.sig)
                SIG_SEL:  act = mdv_sel;
                SIG_STAT: act = status;
                SIG_RXD:  act = rx_data;
                default:  act = {7'b0, gap_irq};
            endcase
            n_cmp++;
            if (act !== e.exp) begin
                n_fail++;
                $display("FAIL %s: got %02h expected %02h", e.name, act, e.exp);
            end
        end
    end

    task automatic chk(input string name, input int sig, input logic [7:0] v);
        exp_t e;
        e.name = name;
        e.sig  = sig;
        e.exp  = v;
        q.push_back(e);
    endtask

    task automatic chk4(input string name, input logic [7:0] sel, input logic [7:0] st,
                        input logic [7:0] rxd, input logic irq);
        chk({name, ".sel"},    SIG_SEL,  sel);
        chk({name, ".status"}, SIG_STAT, st);
        chk({name, ".rx_data"}, SIG_RXD, rxd);
        chk({name, ".irq"},    SIG_IRQ,  {7'b0, irq});
    endtask

    // Let the monitor drain the queue at the next falling edge.
    task automatic sync();
        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL monitor_drain: got %0d pending expected 0", q.size());
            q.delete();
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sel_shift(input logic b);
        seld  = b;
        selck = 1'b1;
        tick();
        selck = 1'b0;
        seld  = 1'b0;
    endtask

    task automatic rx_byte(input logic [7:0] b, input int len);
        mdv_dout     = b;
        mdv_rx_ready = 1'b1;
        repeat (len) tick();
        mdv_rx_ready = 1'b0;
        repeat (2) tick();
    endtask

    task automatic pop();
        rd_data = 1'b1;
        tick();
        rd_data = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        {mdv_gap, mdv_rx_ready, selck, seld, rd_status, rd_data, irq_ack} = '0;
        mdv_dout = 8'h00;
        repeat (2) tick();
        chk4("reset", 8'h00, 8'h00, 8'h00, 1'b0);
        sync();
        reset = 1'b0;
        tick();

        // select shift
        sel_shift(1'b1); chk("sel1", SIG_SEL, 8'h01); sync();
        sel_shift(1'b0); chk("sel2", SIG_SEL, 8'h02); sync();
        sel_shift(1'b0); chk4("sel3", 8'h04, 8'h80, 8'h00, 1'b0); sync();

        // receive with long levels: one push per level
        rx_byte(8'hA5, 13);
        rx_byte(8'h3C, 13);
        chk("rx2.status", SIG_STAT, 8'hA2); chk("rx2.data", SIG_RXD, 8'hA5); sync();
        pop();
        chk("pop1.status", SIG_STAT, 8'h92); chk("pop1.data", SIG_RXD, 8'h3C); sync();
        pop();
        chk("pop2.status", SIG_STAT, 8'h80); chk("pop2.data", SIG_RXD, 8'h00); sync();
        pop();
        chk("pop_empty.status", SIG_STAT, 8'h80); sync();

        // overrun
        for (int i = 1; i <= 5; i++) rx_byte(8'(i), 2);
        chk("ovr.status", SIG_STAT, 8'hC6); chk("ovr.head", SIG_RXD, 8'h01); sync();
        rd_status = 1'b1; tick(); rd_status = 1'b0;
        chk("ovr_clr.status", SIG_STAT, 8'hC2); sync();
        repeat (4) pop();
        chk("drain.status", SIG_STAT, 8'h80); sync();

        // gap flush and interrupt
        rx_byte(8'hB1, 2); rx_byte(8'hB2, 2); rx_byte(8'hB3, 2);
        chk("gap_pre.status", SIG_STAT, 8'hB2); sync();
        mdv_gap = 1'b1;
        tick();
        chk("gap_lat1.irq", SIG_IRQ, 8'h00); sync();
        tick();
        chk4("gap_lat2", 8'h04, 8'h89, 8'h00, 1'b1); sync();
        mdv_gap = 1'b0;
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
        tick();
        chk("ack1.irq", SIG_IRQ, 8'h00); sync();
        mdv_gap = 1'b1;
        tick();
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
        chk("ack_vs_set.irq", SIG_IRQ, 8'h01); sync();
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
        chk("ack2.irq", SIG_IRQ, 8'h00); sync();
        mdv_gap = 1'b0;
        repeat (2) tick();
        chk("gap_low.status", SIG_STAT, 8'h80); sync();

        // full FIFO: push and pop in the same cycle
        for (int i = 0; i < 4; i++) rx_byte(8'h10 + 8'(i), 2);
        chk("full.status", SIG_STAT, 8'hC2); sync();
        mdv_dout = 8'h14; mdv_rx_ready = 1'b1;
        tick();
        rd_data = 1'b1; tick(); rd_data = 1'b0;
        mdv_rx_ready = 1'b0;
        tick();
        chk("fullpp.status", SIG_STAT, 8'hC2); chk("fullpp.head", SIG_RXD, 8'h11); sync();
        pop(); chk("fullpp.d2", SIG_RXD, 8'h12); sync();
        pop(); chk("fullpp.d3", SIG_RXD, 8'h13); sync();
        pop(); chk("fullpp.d4", SIG_RXD, 8'h14); sync();
        pop(); chk("fullpp.empty", SIG_STAT, 8'h80); sync();

        // empty FIFO: only the push takes effect
        mdv_dout = 8'h55; mdv_rx_ready = 1'b1;
        tick();
        rd_data = 1'b1; tick(); rd_data = 1'b0;
        mdv_rx_ready = 1'b0;
        tick();
        chk("emptypp.status", SIG_STAT, 8'h92); chk("emptypp.head", SIG_RXD, 8'h55); sync();
        pop();

        // flush coinciding with push: byte discarded, no overrun
        mdv_dout = 8'h66; mdv_gap = 1'b1; mdv_rx_ready = 1'b1;
        repeat (2) tick();
        mdv_rx_ready = 1'b0;
        tick();
        chk("flushpush.status", SIG_STAT, 8'h89); chk("flushpush.data", SIG_RXD, 8'h00); sync();
        mdv_gap = 1'b0;
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
        tick();

        // reset mid-stream
        repeat (6) sel_shift(1'b0);
        sel_shift(1'b1);
        sel_shift(1'b0);
        mdv_gap = 1'b1;
        repeat (2) tick();
        rx_byte(8'h77, 2);
        rx_byte(8'h88, 2);
        chk4("pre_rst", 8'h02, 8'hAB, 8'h77, 1'b1); sync();
        tick();
        reset = 1'b1;
        chk4("mid_rst", 8'h00, 8'h00, 8'h00, 1'b0); sync();
        tick();
        reset = 1'b0;
        chk("post_rst0.status", SIG_STAT, 8'h00); sync();
        tick();
        chk("post_rst1.irq", SIG_IRQ, 8'h00); sync();
        tick();
        chk("post_rst2.irq", SIG_IRQ, 8'h01); chk("post_rst2.status", SIG_STAT, 8'h09); sync();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
